// File: rtl/pulse_req_arbiter_pkg.sv
// Shared definitions for the pulse request arbiter and related system arbiters.
//   clog2       : ceiling log2 for sizing index/counter fields at elaboration
//   DEFAULT_GAP : idle-gap setting used by system-level arbiter instances
package pulse_req_arbiter_pkg;

    localparam int DEFAULT_GAP = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_req_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : highest-priority index; search ascends from here with wrap
//   gnt    : one-hot winner (all zero when nothing requested)
//   gnt_id : index of the winner (0 when nothing requested)
//   any    : at least one request present
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    // One extra bit so ptr + offset never overflows before the wrap compare,
    // which keeps non-power-of-two N_REQ correct.
    localparam logic [ID_W:0] N_L = (ID_W+1)'(N_REQ);

    logic [ID_W:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= N_L) idx = idx - N_L;
            if (!any && req[idx[ID_W-1:0]]) begin
                any                  = 1'b1;
                gnt[idx[ID_W-1:0]]   = 1'b1;
                gnt_id               = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pulse_req_arbiter.sv
// Edge-to-pulse arbiter: captures rising edges of N_REQ level enables as
// pending events and serves them round-robin as single-cycle pulses with a
// minimum idle gap between pulses.
//   CLK, RST     : clock (rising edge), async active-low reset
//   pulse_en     : per-requester level enable; each 0->1 is one event
//   ovf_clr      : strobe clearing all overflow flags
//   pulse_signal : registered one-cycle pulse per grant
//   pulse_id     : served requester, holds last value between pulses
//   pending      : registered pending-event flags
//   overflow     : sticky lost-event flags
module pulse_req_arbiter
    import pulse_req_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] pulse_en,
    input  logic             ovf_clr,
    output logic             pulse_signal,
    output logic [ID_W-1:0]  pulse_id,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] overflow
);

    localparam int GW = (clog2(GAP + 1) < 1) ? 1 : clog2(GAP + 1);

    logic [N_REQ-1:0] en_q;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] pick;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] drop;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [GW-1:0]    gap_cnt;
    logic             pick_any;
    logic             grant_ok;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req    (pending),
        .ptr    (rr_ptr),
        .gnt    (pick),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    assign rise     = pulse_en & ~en_q;
    assign grant_ok = pick_any && (gap_cnt == '0);
    assign grant    = grant_ok ? pick : '0;
    // A second edge on a requester that is still waiting is lost.
    assign drop     = rise & pending & ~grant;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            en_q         <= '0;
            pending      <= '0;
            overflow     <= '0;
            pulse_signal <= 1'b0;
            pulse_id     <= '0;
            gap_cnt      <= '0;
            rr_ptr       <= '0;
        end else begin
            en_q     <= pulse_en;
            // rise ORed last so an edge arriving as its requester is granted
            // remains pending as a fresh event.
            pending  <= rise | (pending & ~grant);
            // New drops take priority over a coincident clear.
            overflow <= (ovf_clr ? '0 : overflow) | drop;
            if (grant_ok) begin
                pulse_signal <= 1'b1;
                pulse_id     <= pick_id;
                rr_ptr       <= (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);
                gap_cnt      <= GW'(GAP);
            end else begin
                pulse_signal <= 1'b0;
                if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

endmodule
